load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Parametrised successor of the single-word load/store path: computes EA = base+offset,
//  supports byte/half/word access with sign/zero extension, and performs sub-word stores as
//  read-modify-write on a whole-word synchronous memory with a configurable read latency.
//  Checks alignment and range. Sits between the execute stage and the data memory.
//  Uses a valid/ready request and a one-cycle response pulse.
// PARAMETERS
//  XLEN     32  data/address width (byte lanes = XLEN/8; only 32 is supported)
//  MEM_AW   16  memory word-address width; legal byte EA < 2**(MEM_AW+2)
//  MEM_LAT  1   cycles from mem_addr being sampled to mem_rdata being valid (>=1)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  req_valid     in   1       request present
//  req_ready     out  1       unit can accept; high only in IDLE
//  req_store     in   1       0 = load, 1 = store
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       load only: 1 = zero-extend, 0 = sign-extend
//  base          in   XLEN    base address
//  offset        in   XLEN    offset address
//  wdata         in   XLEN    store data; low 8/16/32 bits used
//  resp_valid    out  1       one-cycle completion pulse
//  resp_data     out  XLEN    load result (0 for stores and errors)
//  resp_err      out  1       valid with resp_valid: misaligned, out-of-range or illegal size
//  mem_addr      out  MEM_AW  word address to memory
//  mem_we        out  1       memory write enable
//  mem_wdata     out  XLEN    memory write data
//  mem_rdata     in   XLEN    memory read data
// BEHAVIOUR
//  - Reset (async, while rst_n=0): state IDLE. req_ready, resp_valid, resp_err, mem_we = 0.
//    resp_data, mem_addr, mem_wdata = 0. req_ready rises in the first cycle after release.
//  - Accept on a rising edge with req_valid & req_ready. All request fields and
//    EA = base+offset are latched; the sum wraps mod 2**XLEN.
//    "Cycle n" = nth cycle after the accept edge.
//  - Error when any of these holds: req_size=11; half with EA[0]!=0; word with EA[1:0]!=0;
//    EA[XLEN-1:MEM_AW+2]!=0. On error: no memory access (mem_we stays 0);
//    resp_valid=1, resp_err=1, resp_data=0 in cycle 1.
//  - FSM: IDLE, RD, WAIT, WR, RESP. mem_addr=EA[MEM_AW+1:2], held from RD/WR to RESP.
//    - Load: RD (cycle 1) -> WAIT (MEM_LAT cycles, counter) -> RESP.
//      mem_rdata is captured at the end of the last WAIT cycle.
//      resp_valid in cycle MEM_LAT+2 (3 at default).
//    - Word store: WR (cycle 1, mem_we=1, mem_wdata=wdata) -> RESP; resp_valid in cycle 2.
//    - Byte/half store: RD -> WAIT -> WR -> RESP. WR merges the new lane(s) into the
//      captured word; other lanes are unchanged. mem_we=1 in cycle MEM_LAT+2;
//      resp_valid in cycle MEM_LAT+3.
//  - Lane selection is little-endian: byte lane = EA[1:0]; half lane = EA[1].
//    Load extracts the lane and extends per req_unsigned. Word loads ignore req_unsigned.
//  - RESP lasts exactly one cycle, then IDLE; req_ready=1 again in the next cycle.
//    No back-to-back accept in the RESP cycle. resp_data/resp_err hold their value until
//    the next response.
//  - mem_we is high only in WR, and only for one cycle per store.
//  - Reset mid-operation aborts immediately; mem_we drops asynchronously and no response
//    is issued. A sub-word store reset before WR leaves memory unchanged.
//  - Requests arriving while req_ready=0 are ignored; the producer holds them until accepted.
// TESTING
//  1. Word store base=0x100, off=0x4, wdata=0x11223344 -> mem_we cycle 1 @mem_addr=0x41;
//     word load same EA -> resp_data=0x11223344 in cycle 3, resp_err=0.
//  2. Byte store wdata=0xAA at EA=0x107 over 0x11223344 -> mem_we cycle 3,
//     mem_wdata=0xAA223344; then a half store 0xBEEF at 0x104 -> 0xAA22BEEF.
//  3. Memory word 0x00008080 at 0x200: signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080;
//     signed half -> 0xFFFF8080.
//  4. Half load EA=0x101 / word store EA=0x102 / size=11 -> resp_err=1 in cycle 1,
//     mem_we never asserted.
//  5. EA=0x00040000 (MEM_AW=16) -> resp_err=1. Wrap check: base=0xFFFFFFFC, off=8 ->
//     EA=4, legal access to word 1.
//  6. Assert rst_n=0 in cycle 2 of a byte store -> mem_we never 1, no resp_valid,
//     memory word unchanged. req_ready=1 after release; a new load succeeds.
//     Repeat tests 1-3 with MEM_LAT=3 and check the latencies scale.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a whole-word synchronous data memory.
// Computes EA = base + offset, checks size/alignment/range, performs byte/half/word
// loads with sign or zero extension, and does sub-word stores as read-modify-write.
// One request at a time: valid/ready handshake in, single-cycle response pulse out.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int MEM_AW  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   base,
   input  logic [XLEN-1:0]   offset,
   input  logic [XLEN-1:0]   wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   // Byte-address width of the legal memory window; EA bits above it must be zero.
   localparam int EAW = MEM_AW + 2;
   localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic            ready_q, ready_d;
   logic            store_q, store_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [EAW-1:0]  ea_q, ea_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic            resp_err_q, resp_err_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [XLEN-1:0] ea_sum;
   logic            acc_err;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] merged;

   // Effective address of the offered request and whether it is an illegal access
   always_comb begin
      ea_sum  = base + offset;
      acc_err = (req_size == 2'b11)
             || ((req_size == SZ_H) && ea_sum[0])
             || ((req_size == SZ_W) && (ea_sum[1:0] != 2'b00))
             || ((ea_sum >> EAW) != '0);
   end

   // Little-endian lane extraction from the returning memory word, then extension
   always_comb begin
      byte_sel = 8'(mem_rdata >> {ea_q[1:0], 3'b000});
      half_sel = 16'(mem_rdata >> {ea_q[1], 4'b0000});
      case (size_q)
         SZ_B:    load_val = uns_q ? {{(XLEN-8){1'b0}}, byte_sel}
                                   : {{(XLEN-8){byte_sel[7]}}, byte_sel};
         SZ_H:    load_val = uns_q ? {{(XLEN-16){1'b0}}, half_sel}
                                   : {{(XLEN-16){half_sel[15]}}, half_sel};
         default: load_val = mem_rdata;
      endcase
   end

   // Store merge: each byte lane takes new data when addressed, else keeps the read word.
   // A word store addresses every lane, so rdata_q is irrelevant on that path.
   for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_sel;
      logic [7:0] lane_src;
      assign lane_sel = (size_q == SZ_W)
                     || ((size_q == SZ_H) && (ea_q[1] == LANE[1]))
                     || ((size_q == SZ_B) && (ea_q[1:0] == LANE));
      assign lane_src = (size_q == SZ_W) ? wdata_q[8*gi +: 8]
                      : (size_q == SZ_H) ? wdata_q[8*(gi%2) +: 8]
                      : wdata_q[7:0];
      assign merged[8*gi +: 8] = lane_sel ? lane_src : rdata_q[8*gi +: 8];
   end

   // Next-state logic: request capture, read-latency countdown, response formation
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b1;
      store_d     = store_q;
      size_d      = size_q;
      uns_d       = uns_q;
      ea_d        = ea_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && ready_q) begin
               store_d = req_store;
               size_d  = req_size;
               uns_d   = req_unsigned;
               ea_d    = ea_sum[EAW-1:0];
               wdata_d = wdata;
               if (acc_err) begin
                  state_d     = S_RESP;
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
               end else if (req_store && (req_size == SZ_W)) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_WAIT;
            cnt_d   = CW'(MEM_LAT - 1);
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = mem_rdata;
               if (store_q) begin
                  state_d = S_WR;
               end else begin
                  state_d     = S_RESP;
                  resp_data_d = load_val;
                  resp_err_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WR: begin
            state_d     = S_RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b0;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything visible at the ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         store_q     <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         ea_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         store_q     <= store_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         ea_q        <= ea_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // ready_q keeps req_ready low during reset and lets it rise on the first edge after
   assign req_ready  = ready_q && (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign mem_addr   = ea_q[EAW-1:2];
   assign mem_we     = (state_q == S_WR);
   assign mem_wdata  = merged;

endmodule
